// File: rtl/inst_rom_pkg.sv
// Shared types and constants for the instruction ROM responder.
package inst_rom_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_WAIT_CYC = 1;

  // Wait-state counter width; WAIT_CYC is limited to 0..15.
  localparam int CNT_W = 4;

  // Returned in place of a word when the fetch address is bad.
  localparam logic [31:0] INST_NOP = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/inst_rom_mem.sv
// Word-addressed instruction store: one write port for program load and
// one clocked read port. The array itself is never reset, so loaded code
// survives a reset; only the read register is cleared.
module inst_rom_mem
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  // Program-load write port; accepted every cycle regardless of the reader.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Clocked read: a write to the same word on the same edge is not seen,
  // the old word is captured.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= INST_NOP;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction fetch responder: accepts one request at a time, waits a
// fixed number of cycles, then presents the word (or an error) until the
// fetcher takes it.
module inst_rom_resp
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_inst,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              busy
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       addr_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              addr_bad;
  logic              enter_resp;
  logic [31:0]       rd_data;

  // Misaligned, or any address bit above the array is set.
  assign addr_bad   = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'h0);

  // The memory read is launched on the same edge that moves WAIT -> RESP.
  assign enter_resp = (state_q == WAIT) && (cnt_q == '0);

  // Request/response FSM. Every accept spends WAIT_CYC+1 cycles in WAIT so
  // the response appears 1+WAIT_CYC edges after the accept edge, including
  // the WAIT_CYC=0 case.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= WAIT;
            addr_q  <= req_addr;
            cnt_q   <= CNT_W'(WAIT_CYC);
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= addr_bad;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  inst_rom_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .rst_ni  (rst),
    .we_i    (ld_en),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .re_i    (enter_resp),
    .raddr_i (addr_q[ADDR_W+1:2]),
    .rdata_o (rd_data)
  );

  assign req_ready = rst && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_inst  = rsp_err_q ? INST_NOP : rd_data;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench for inst_rom_resp: three instances with WAIT_CYC = 0, 1, 3 share a
// clock and reset; a word-array reference model predicts every response.
module tb_inst_rom_resp;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rv [N];
  logic        rr [N];
  logic        le [N];
  logic [31:0] ra [N];
  logic [31:0] ld [N];
  logic [9:0]  la [N];
  logic        rqr[N];
  logic        rsv[N];
  logic        rse[N];
  logic        bsy[N];
  logic [31:0] rsi[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    inst_rom_resp #(
      .ADDR_W   (10),
      .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (rv[g]),
      .req_ready (rqr[g]),
      .req_addr  (ra[g]),
      .rsp_valid (rsv[g]),
      .rsp_ready (rr[g]),
      .rsp_inst  (rsi[g]),
      .rsp_err   (rse[g]),
      .ld_en     (le[g]),
      .ld_addr   (la[g]),
      .ld_data   (ld[g]),
      .busy      (bsy[g])
    );
  end

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl [N][1024];

  function automatic int wc_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  // Reference: bad if not word aligned or beyond 1024 words (4 KiB).
  function automatic logic exp_err(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= 32'h1000);
  endfunction

  function automatic logic [31:0] exp_inst(input int k, input logic [31:0] a);
    if (exp_err(a)) return 32'h0;
    return mdl[k][a / 4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int k, input int idx, input logic [31:0] d);
    le[k] = 1'b1; la[k] = 10'(idx); ld[k] = d;
    @(posedge clk); #1;
    le[k] = 1'b0;
    mdl[k][idx] = d;
  endtask

  // Issue one fetch with rsp_ready=1; returns latency in edges after accept.
  task automatic fetch(input int k, input logic [31:0] a, output int lat,
                       output logic [31:0] inst, output logic err);
    int c;
    c = 0;
    while (!rqr[k] && c < 50) begin @(posedge clk); #1; c++; end
    if (!rqr[k]) chk("req_ready_timeout", 32'(rqr[k]), 32'd1);
    rv[k] = 1'b1; ra[k] = a;
    @(posedge clk); #1;
    rv[k] = 1'b0; ra[k] = $urandom;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (rsv[k]) break;
    end
    if (!rsv[k]) chk("rsp_valid_timeout", 32'(rsv[k]), 32'd1);
    inst = rsi[k];
    err  = rse[k];
    @(posedge clk); #1;
  endtask

  task automatic check_fetch(input int k, input logic [31:0] a, input string tag);
    int          lat;
    logic [31:0] inst;
    logic        err;
    fetch(k, a, lat, inst, err);
    chk({tag, "_inst"}, inst, exp_inst(k, a));
    chk({tag, "_err"}, 32'(err), 32'(exp_err(a)));
    chk({tag, "_lat"}, 32'(lat), 32'(1 + wc_of(k)));
  endtask

  initial begin
    logic [31:0] prog [4];
    logic [31:0] old_w;
    logic [31:0] held;
    logic        seen;
    int          c;
    int          q[$];

    prog[0] = 32'h34011100; prog[1] = 32'h34020020;
    prog[2] = 32'h3403ff00; prog[3] = 32'h3404ffff;
    for (int k = 0; k < N; k++) begin
      rv[k] = 1'b0; rr[k] = 1'b1; le[k] = 1'b0;
      ra[k] = '0; ld[k] = '0; la[k] = '0;
    end

    // Reset values
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_valid%0d", k), 32'(rsv[k]), 32'd0);
      chk($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
      chk($sformatf("rst_inst%0d", k), rsi[k], 32'h0);
      chk($sformatf("rst_err%0d", k), 32'(rse[k]), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) chk($sformatf("rst_ready%0d", k), 32'(rqr[k]), 32'd1);

    // Program load and in-order fetches on every wait-state setting
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 4; i++) load(k, i, prog[i]);
      for (int i = 0; i < 4; i++) check_fetch(k, 32'(i * 4), $sformatf("seq%0d_%0d", k, i));
    end

    // Bad addresses
    check_fetch(1, 32'h6, "misalign");
    check_fetch(1, 32'h1000, "range");

    // Backpressure: response held, new requests ignored
    rr[1] = 1'b0; rv[1] = 1'b1; ra[1] = 32'h4;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    c = 0;
    while (!rsv[1] && c < 40) begin @(posedge clk); #1; c++; end
    chk("stall_reach", 32'(rsv[1]), 32'd1);
    held = exp_inst(1, 32'h4);
    for (int i = 0; i < 5; i++) begin
      rv[1] = 1'b1; ra[1] = $urandom & 32'hFFC;
      @(posedge clk); #1;
      chk($sformatf("stall_valid%0d", i), 32'(rsv[1]), 32'd1);
      chk($sformatf("stall_inst%0d", i), rsi[1], held);
      chk($sformatf("stall_ready%0d", i), 32'(rqr[1]), 32'd0);
    end
    rv[1] = 1'b0; rr[1] = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", 32'(rsv[1]), 32'd0);
    chk("stall_release_busy", 32'(bsy[1]), 32'd0);

    // Write to the word being read on the edge that enters RESP
    rv[1] = 1'b1; ra[1] = 32'h8;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    repeat (wc_of(1)) begin @(posedge clk); #1; end
    old_w = mdl[1][2];
    le[1] = 1'b1; la[1] = 10'd2; ld[1] = 32'hDEADBEEF;
    @(posedge clk); #1;
    le[1] = 1'b0;
    mdl[1][2] = 32'hDEADBEEF;
    chk("wr_race_valid", 32'(rsv[1]), 32'd1);
    chk("wr_race_inst", rsi[1], old_w);
    @(posedge clk); #1;
    check_fetch(1, 32'h8, "refetch");

    // Reset in the middle of WAIT
    rv[2] = 1'b1; ra[2] = 32'h4;
    @(posedge clk); #1;
    rv[2] = 1'b0;
    @(posedge clk); #1;
    chk("midwait_busy_pre", 32'(bsy[2]), 32'd1);
    rst = 1'b0;
    #1;
    chk("midwait_valid", 32'(rsv[2]), 32'd0);
    chk("midwait_busy", 32'(bsy[2]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsv[2]) seen = 1'b1;
    end
    chk("midwait_no_rsp", 32'(seen), 32'd0);
    check_fetch(2, 32'h4, "post_rst");

    // Randomized loads and fetches against the model
    load(1, 1023, $urandom);
    q.push_back(1023);
    for (int i = 0; i < 15; i++) begin
      c = $urandom_range(4, 1022);
      load(1, c, $urandom);
      q.push_back(c);
    end
    check_fetch(1, 32'hFFC, "top_word");
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      c = $urandom_range(0, 9);
      if (c < 6)      a = 32'(q[$urandom_range(0, q.size() - 1)] * 4);
      else if (c < 8) a = 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
      else            a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
      check_fetch(1, a, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
